// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared state encoding and command codes for the RTC bus sequencer
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_SET,
        A_STB,
        A_HLD,
        D_SET,
        D_STB,
        D_HLD
    } state_e;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;

    // Fixed phase order; D_HLD wraps back to IDLE.
    function automatic state_e next_phase(input state_e s);
        case (s)
            A_SET:   next_phase = A_STB;
            A_STB:   next_phase = A_HLD;
            A_HLD:   next_phase = D_SET;
            D_SET:   next_phase = D_STB;
            D_STB:   next_phase = D_HLD;
            default: next_phase = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - per-phase down-counter, expire marks the last cycle of a phase
module rtc_phase_timer #(
    parameter int PHASE_CYC = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(PHASE_CYC + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(PHASE_CYC - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Parked at zero while idle; the sequencer ignores expire in IDLE.
    assign expire = (count_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - multiplexed address/data bus cycle sequencer for the RTC chip
module rtc_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int N         = 8,
    parameter int PHASE_CYC = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] addr_in,
    input  logic [N-1:0] wdata_in,
    input  logic [1:0]   cmd_in,
    output logic [N-1:0] rdata_out,
    output logic         busy,
    output logic         done,
    output logic         AD,
    output logic         CS,
    output logic         WR,
    output logic         RD,
    inout  wire  [N-1:0] salient
);

    state_e       state_q, state_d;
    logic [1:0]   cmd_q, cmd_d;
    logic         op_wr_q, op_wr_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic [N-1:0] bus_q, bus_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         ad_q, ad_d;
    logic         cs_q, cs_d;
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic         drv_en_q, drv_en_d;
    logic         drv_en;
    logic         start;
    logic         expire;
    logic         load;
    logic         addr_phase;
    logic         data_phase;

    rtc_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_in;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        // Edge-triggered start; done_q blocks a restart in the completion cycle.
        start = (state_q == IDLE) && !done_q && (cmd_q == CMD_IDLE) &&
                ((cmd_in == CMD_WR) || (cmd_in == CMD_RD));
        load  = start || ((state_q != IDLE) && expire);

        if (start) begin
            state_d = A_SET;
            op_wr_d = (cmd_in == CMD_WR);
            addr_d  = addr_in;
            wdata_d = wdata_in;
        end else if ((state_q != IDLE) && expire) begin
            state_d = next_phase(state_q);
        end

        if ((state_q == D_STB) && expire && !op_wr_q) begin
            rdata_d = salient;
        end

        done_d = (state_q == D_HLD) && expire;
        busy_d = (state_d != IDLE);

        // Strobes are decoded from the next state so they leave the flops clean.
        addr_phase = (state_d == A_SET) || (state_d == A_STB) || (state_d == A_HLD);
        data_phase = (state_d == D_SET) || (state_d == D_STB) || (state_d == D_HLD);
        ad_d     = !addr_phase;
        cs_d     = !((state_d == A_STB) || (state_d == D_STB));
        wr_d     = !((state_d == A_STB) || ((state_d == D_STB) && op_wr_d));
        rd_d     = !((state_d == D_STB) && !op_wr_d);
        drv_en_d = addr_phase || (data_phase && op_wr_d);
        bus_d    = addr_phase ? addr_d : wdata_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cmd_q    <= CMD_IDLE;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            bus_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ad_q     <= 1'b1;
            cs_q     <= 1'b1;
            wr_q     <= 1'b1;
            rd_q     <= 1'b1;
            drv_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            bus_q    <= bus_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ad_q     <= ad_d;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            drv_en_q <= drv_en_d;
        end
    end

    assign drv_en    = drv_en_q;
    assign salient   = drv_en ? bus_q : 'z;
    assign rdata_out = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign AD        = ad_q;
    assign CS        = cs_q;
    assign WR        = wr_q;
    assign RD        = rd_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - directed table-driven bench for rtc_bus_ctrl with PHASE_CYC=4
module tb_rtc_bus_ctrl;

    localparam int P = 4;

    typedef struct {
        logic       ad;
        logic       cs;
        logic       wr;
        logic       rd;
        logic       drv;
        logic [7:0] bus;
    } phase_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr_in;
    logic [7:0] wdata_in;
    logic [1:0] cmd_in;
    logic [7:0] rdata_out;
    logic       busy;
    logic       done;
    logic       AD;
    logic       CS;
    logic       WR;
    logic       RD;
    wire  [7:0] salient;

    int checks   = 0;
    int failures = 0;

    phase_vec_t wr_tab[6];
    phase_vec_t rd_tab[6];

    rtc_bus_ctrl #(.N(8), .PHASE_CYC(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .cmd_in    (cmd_in),
        .rdata_out (rdata_out),
        .busy      (busy),
        .done      (done),
        .AD        (AD),
        .CS        (CS),
        .WR        (WR),
        .RD        (RD),
        .salient   (salient)
    );

    // RTC chip model: drives read data only while RD is low.
    assign salient = (RD == 1'b0) ? 8'h3C : 'z;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves cmd_in at 00 long enough for cmd_q to settle, then raises cmd; caller is in cycle S.
    task automatic issue(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] d);
        step();
        cmd_in = 2'b00;
        step();
        step();
        addr_in  = a;
        wdata_in = d;
        cmd_in   = cmd;
    endtask

    task automatic run_txn(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] d,
                           input bit is_wr);
        phase_vec_t e;
        issue(cmd, a, d);
        for (int k = 1; k <= 6 * P + 1; k++) begin
            step();
            if (k <= 6 * P) begin
                e = is_wr ? wr_tab[(k - 1) / P] : rd_tab[(k - 1) / P];
                check($sformatf("%s_c%0d_strobes", is_wr ? "wr" : "rd", k),
                      {25'd0, AD, CS, WR, RD, dut.drv_en, busy, done},
                      {25'd0, e.ad, e.cs, e.wr, e.rd, e.drv, 1'b1, 1'b0});
                if (e.drv) begin
                    check($sformatf("%s_c%0d_bus", is_wr ? "wr" : "rd", k), {24'd0, salient},
                          {24'd0, e.bus});
                end
            end else begin
                check($sformatf("%s_done", is_wr ? "wr" : "rd"),
                      {25'd0, AD, CS, WR, RD, dut.drv_en, busy, done}, 32'b1111001);
            end
        end
    endtask

    initial begin
        int bad;
        int n_done;
        int n_rd;

        wr_tab[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0A};
        wr_tab[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0A};
        wr_tab[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0A};
        wr_tab[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A};
        wr_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};
        wr_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A};
        rd_tab[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h21};
        rd_tab[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21};
        rd_tab[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h21};
        rd_tab[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        rd_tab[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        rd_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

        reset    = 1'b0;
        cmd_in   = 2'b00;
        addr_in  = 8'h00;
        wdata_in = 8'h00;
        repeat (3) step();
        check("reset_outputs", {24'd0, AD, CS, WR, RD, dut.drv_en, busy, done, 1'b0},
              {24'd0, 8'b11110000});
        check("reset_rdata", {24'd0, rdata_out}, 32'h00);
        reset = 1'b1;

        // Write 0x5A to 0x0A; rdata must stay at its reset value.
        run_txn(2'b01, 8'h0A, 8'h5A, 1'b1);
        check("wr_rdata_unchanged", {24'd0, rdata_out}, 32'h00);

        // Read of 0x21 captures the model's 0x3C.
        run_txn(2'b10, 8'h21, 8'h00, 1'b0);
        check("rd_rdata", {24'd0, rdata_out}, 32'h3C);

        // Reserved command never starts anything.
        issue(2'b11, 8'h11, 8'h22);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (busy || !CS || !WR || !RD || !AD || done) bad++;
        end
        check("cmd11_idle_cycles", bad, 0);

        // A read edge during A_HLD of a write is dropped.
        issue(2'b01, 8'h33, 8'h44);
        n_done = 0;
        n_rd   = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 9) cmd_in = 2'b00;
            if (k == 10) cmd_in = 2'b10;
            if (done) n_done++;
            if (!RD) n_rd++;
        end
        check("overlap_done_count", n_done, 1);
        check("overlap_rd_low_cycles", n_rd, 0);
        check("overlap_rdata_kept", {24'd0, rdata_out}, 32'h3C);

        // A held command does not retrigger after done.
        issue(2'b01, 8'h55, 8'h66);
        for (int k = 1; k <= 6 * P; k++) step();
        step();
        check("held_first_done", {30'd0, busy, done}, 32'b01);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (busy || done || !CS) bad++;
        end
        check("held_no_retrigger", bad, 0);

        // Asynchronous reset in the middle of a write's D_STB.
        issue(2'b01, 8'h0A, 8'h5A);
        for (int k = 1; k <= 18; k++) step();
        check("pre_reset_in_dstb", {28'd0, AD, CS, WR, busy}, 32'b1001);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_strobes", {26'd0, AD, CS, WR, RD, dut.drv_en, busy},
              32'b111100);
        check("async_reset_rdata", {24'd0, rdata_out}, 32'h00);
        cmd_in = 2'b00;
        step();
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (busy || done || !CS || !AD) bad++;
        end
        check("post_reset_idle", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus-cycle sequencer between the PicoBlaze output-port registers and the external multiplexed-address/data real-time-clock chip. It takes the latched register address (port 0x00), write data (port 0x01) and command bits (port 0x02) and runs one complete multiplexed bus cycle: an address phase, then a data phase, with active-low AD/CS/WR/RD strobes and fixed phase timing. Read data and status return to input port 0x00.

## Interface
- `N`, default 8: width of the address/data bus.
- `PHASE_CYC`, default 10: clocks per bus phase; legal values ≥1 (10 = 100 ns at 100 MHz).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr_in`  in  N  RTC register address (from port_out00).
- `wdata_in`  in  N  write data (from port_out01).
- `cmd_in`  in  2  command (from port_out02[1:0]): 00 idle, 01 write, 10 read, 11 reserved.
- `rdata_out`  out  N  last read data (to port_in00); reset 0.
- `busy`  out  1  high from the cycle after start until `done`; reset 0.
- `done`  out  1  one-cycle pulse at end of transaction; reset 0.
- `AD`  out  1  address/data select, low = address phase; reset 1.
- `CS`  out  1  chip select, active-low; reset 1.
- `WR`  out  1  write strobe, active-low; reset 1.
- `RD`  out  1  read strobe, active-low; reset 1.
- `salient`  inout  N  multiplexed bus; high-Z at reset and when not driving.

## Operation
- `cmd_in` is registered into `cmd_q` every cycle. Start = IDLE and `cmd_q`==00 and `cmd_in` ∈ {01,10}. `addr_in`, `wdata_in` and the operation type are captured on the start cycle.
- `cmd_in`==11 never starts a transaction. A rising command edge seen outside IDLE is dropped. A held nonzero command causes no retrigger; firmware writes 00 before issuing the next command.
- States: IDLE → A_SET → A_STB → A_HLD → D_SET → D_STB → D_HLD → IDLE. Each non-IDLE state lasts exactly PHASE_CYC cycles.
- IDLE: AD=CS=WR=RD=1, bus Z.
- A_SET: AD=0, bus drives the address.
- A_STB: AD=0, CS=0, WR=0, bus drives the address.
- A_HLD: AD=0, CS=WR=1, bus keeps driving the address.
- D_SET: AD=1. A write drives `wdata`; a read releases the bus (Z).
- D_STB: AD=1, CS=0, with WR=0 for a write or RD=0 for a read. Bus drive is as in D_SET.
- D_HLD: CS=WR=RD=1, AD=1. A write keeps driving data; a read keeps the bus Z.
- Read capture: `rdata_out` ← `salient` on the last cycle of D_STB, before RD deasserts. Write transactions leave `rdata_out` unchanged.
- Exit from D_HLD: `done` pulses and `busy` falls in the same cycle.
- All strobes and the bus-drive enable are registered outputs, so strobes are glitch-free.

## Timing
- Start cycle S (the cycle `cmd_in` edge is sampled): state = A_SET from S+1; `busy`=1 from S+1.
- Phase k (0..5) spans cycles S+1+k·PHASE_CYC through S+(k+1)·PHASE_CYC.
- `done` is high in cycle S+6·PHASE_CYC+1, back in IDLE. Total latency is 6·PHASE_CYC+1 cycles.
- A new start is accepted at the earliest in the cycle after `done`.
- Asynchronous reset while active: all strobes go to 1, bus goes to Z and the state goes to IDLE immediately, with no clock needed. `busy`/`done` clear to 0 and `rdata_out` clears to 0. `cmd_q` resets to 00, so a command held at release starts a new transaction on the first clock.
- Phase counter is `$clog2(PHASE_CYC+1)` bits wide, loaded with PHASE_CYC-1 on each state entry, and advances the state at 0.

## Structure
- Package `rtc_bus_pkg`: state enum (IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD) and command constants CMD_IDLE=2'b00, CMD_WR=2'b01, CMD_RD=2'b10.
- One sub-module: `rtc_phase_timer`, a down-counter with `load` input, parameter PHASE_CYC, and a one-cycle `expire` output.
- Tri-state is a single `assign salient = drv_en ? bus_q : 'z`.

## Test plan
- Write with PHASE_CYC=4, addr 0x0A, data 0x5A, cmd 00→01:
  - AD low for 12 cycles with bus=0x0A; CS/WR low for cycles 5–8 only.
  - Then AD high with bus=0x5A; CS/WR low for cycles 17–20.
  - `done` in cycle 25; `rdata_out` unchanged.
- Read of addr 0x21, with the bus model driving 0x3C while RD is low:
  - Bus is Z from D_SET onward, RD low for cycles 17–20, WR stays 1.
  - `rdata_out`=0x3C at `done`.
- cmd 00→11: no strobe activity and `busy` stays 0 for 50 cycles.
- cmd 00→01 then 00→10 during A_HLD: only the write executes, and exactly one `done` occurs.
- cmd held at 01 for 100 cycles after `done`: no second transaction.
- Reset asserted mid-D_STB of a write: CS/WR/AD=1 and bus Z in the same cycle; `busy`=0. After release with cmd=00, the block stays idle.
